// File: rtl/fx2_pkg.sv
// Shared definitions for the FX2 slave-FIFO emulator: endpoint addresses,
// the EP6 entry layout and a saturating event counter helper.
package fx2_pkg;

    localparam logic [1:0] EP2 = 2'b00;
    localparam logic [1:0] EP4 = 2'b01;
    localparam logic [1:0] EP6 = 2'b10;
    localparam logic [1:0] EP8 = 2'b11;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } ep6_entry_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/fx2_emu_fifo.sv
// Synchronous FIFO with combinational head and a strobe that marks the
// most recently written entry as the end of a packet (MSB of the word).
module fx2_emu_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     set_tail_last,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [AW-1:0]    tail_idx;
    logic             do_pop;
    logic             do_push;

    assign count    = wr_ptr_reg - rd_ptr_reg;
    assign full     = (count == (AW + 1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // A same-cycle pop frees the slot for a push into a full FIFO.
    assign do_push  = push && (!full || do_pop);
    assign tail_idx = wr_ptr_reg[AW-1:0] - 1'b1;
    assign head     = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        else if (set_tail_last && !empty)
            mem[tail_idx][WIDTH-1] <= 1'b1;
    end

endmodule

// File: rtl/fx2_slave_fifo_emu.sv
// FX2 side of the slave-FIFO interface: EP2 OUT FIFO read by the FPGA, EP6 IN
// FIFO written by the FPGA, with host-side stream ports and error counters.
module fx2_slave_fifo_emu
    import fx2_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int PKT_SIZE = 512
) (
    input  logic       IFCLK,
    input  logic       reset,
    input  logic       SLOE,
    input  logic       SLRD,
    input  logic       SLWR,
    input  logic [1:0] FIFOADR,
    input  logic       PKTEND,
    input  logic [7:0] FDO,
    output logic [7:0] FDI,
    output logic       FLAGA,
    output logic       FLAGB,
    output logic       FLAGC,
    output logic       FLAGD,
    input  logic [7:0] host_out_data,
    input  logic       host_out_valid,
    output logic       host_out_ready,
    output logic [7:0] host_in_data,
    output logic       host_in_last,
    output logic       host_in_valid,
    input  logic       host_in_ready,
    output logic [7:0] underrun_cnt,
    output logic [7:0] overrun_cnt,
    output logic [7:0] zlp_cnt
);

    localparam int CW   = $clog2(DEPTH) + 1;
    localparam int PB_W = $clog2(PKT_SIZE) + 1;

    logic [7:0]    ep2_head;
    logic [CW-1:0] ep2_count;
    logic          ep2_full, ep2_empty;
    logic          ep2_rd, ep2_pop, ep2_push;

    ep6_entry_t    ep6_head, ep6_in;
    logic [CW-1:0] ep6_count;
    logic          ep6_full, ep6_empty;
    logic          ep6_wr, ep6_pop, ep6_accept;

    logic [PB_W-1:0] pkt_bytes_reg;
    logic [PB_W-1:0] pkt_inc;
    logic            wr_last;
    logic            pktend_only, tail_close;
    logic            ep6_tail_last_reg;
    logic            flaga_reg, flagc_reg;
    logic [7:0]      underrun_reg, overrun_reg, zlp_reg;

    assign ep2_rd   = SLRD && (FIFOADR == EP2);
    assign ep2_pop  = ep2_rd && !ep2_empty;
    assign ep2_push = host_out_valid && host_out_ready;

    assign ep6_wr     = SLWR && (FIFOADR == EP6);
    assign ep6_pop    = host_in_valid && host_in_ready;
    assign ep6_accept = ep6_wr && (!ep6_full || ep6_pop);

    assign pkt_inc     = pkt_bytes_reg + 1'b1;
    assign wr_last     = PKTEND || (pkt_inc == PB_W'(PKT_SIZE));
    assign ep6_in      = '{last: wr_last, data: FDO};
    // A bare PKTEND closes an open tail packet; with nothing open it is a ZLP.
    assign pktend_only = PKTEND && !SLWR && (FIFOADR == EP6);
    assign tail_close  = pktend_only && !ep6_empty && !ep6_tail_last_reg;

    fx2_emu_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_ep2 (
        .clk           (IFCLK),
        .rst_n         (reset),
        .push          (ep2_push),
        .push_data     (host_out_data),
        .pop           (ep2_pop),
        .set_tail_last (1'b0),
        .head          (ep2_head),
        .count         (ep2_count),
        .full          (ep2_full),
        .empty         (ep2_empty)
    );

    fx2_emu_fifo #(.WIDTH(9), .DEPTH(DEPTH)) u_ep6 (
        .clk           (IFCLK),
        .rst_n         (reset),
        .push          (ep6_accept),
        .push_data     (ep6_in),
        .pop           (ep6_pop),
        .set_tail_last (tail_close),
        .head          (ep6_head),
        .count         (ep6_count),
        .full          (ep6_full),
        .empty         (ep6_empty)
    );

    assign host_out_ready = !ep2_full;
    assign host_in_valid  = !ep6_empty;
    assign host_in_data   = ep6_empty ? 8'h00 : ep6_head.data;
    assign host_in_last   = !ep6_empty && ep6_head.last;
    assign FDI            = (SLOE && (FIFOADR == EP2) && !ep2_empty) ? ep2_head : 8'h00;

    assign FLAGA        = flaga_reg;
    assign FLAGB        = 1'b0;
    assign FLAGC        = flagc_reg;
    assign FLAGD        = 1'b0;
    assign underrun_cnt = underrun_reg;
    assign overrun_cnt  = overrun_reg;
    assign zlp_cnt      = zlp_reg;

    always_ff @(posedge IFCLK or negedge reset) begin
        if (!reset) begin
            flaga_reg         <= 1'b0;
            flagc_reg         <= 1'b0;
            pkt_bytes_reg     <= '0;
            ep6_tail_last_reg <= 1'b0;
            underrun_reg      <= 8'h00;
            overrun_reg       <= 8'h00;
            zlp_reg           <= 8'h00;
        end else begin
            // Flags follow the counts with one cycle of lag, as on the real part.
            flaga_reg <= (ep2_count != '0);
            flagc_reg <= (ep6_count < CW'(DEPTH));

            if (ep2_rd && ep2_empty)
                underrun_reg <= sat_inc(underrun_reg);
            if (ep6_wr && !ep6_accept)
                overrun_reg <= sat_inc(overrun_reg);

            if (ep6_accept) begin
                pkt_bytes_reg     <= wr_last ? '0 : pkt_inc;
                ep6_tail_last_reg <= wr_last;
            end else if (tail_close) begin
                pkt_bytes_reg     <= '0;
                ep6_tail_last_reg <= 1'b1;
            end else if (pktend_only) begin
                zlp_reg <= sat_inc(zlp_reg);
            end
        end
    end

endmodule

// File: doc/fx2_slave_fifo_emu.md
# fx2_slave_fifo_emu

Synthesizable model of the Cypress FX2 side of the slave-FIFO interface, i.e. the responder that the `usbp_myhdl` FIFO master drives via SLOE/SLRD/SLWR/FIFOADR/PKTEND. It holds an EP2 OUT FIFO (host→FPGA) and an EP6 IN FIFO (FPGA→host) and drives FLAGA–FLAGD and the FPGA's FDI bus. It also exposes stream ports so a bench or loopback harness can act as the USB host. It sits across the FX2 pins from `usbp_myhdl` in simulation and in FPGA-only loopback builds.

## Interface
- `DEPTH`, 16: entries per endpoint FIFO; power of two, ≥4.
- `PKT_SIZE`, 512: EP6 bytes per packet before an automatic packet end.
- `IFCLK` in 1: single clock; all logic is rising-edge.
- `reset` in 1: asynchronous, active-low reset.
- `SLOE` in 1: output enable, active-high.
- `SLRD` in 1: read strobe, active-high.
- `SLWR` in 1: write strobe, active-high.
- `FIFOADR` in 2: 00=EP2, 01=EP4, 10=EP6, 11=EP8.
- `PKTEND` in 1: commit the current EP6 packet, active-high.
- `FDO` in 8: byte from the FPGA.
- `FDI` out 8: byte to the FPGA.
- `FLAGA` out 1: EP2 not-empty.
- `FLAGB` out 1: EP4 not-empty; tied 0.
- `FLAGC` out 1: EP6 not-full.
- `FLAGD` out 1: EP8 not-full; tied 0.
- `host_out_data` in 8, `host_out_valid` in 1, `host_out_ready` out 1: push side of EP2.
- `host_in_data` out 8, `host_in_last` out 1, `host_in_valid` out 1, `host_in_ready` in 1: pop side of EP6.
- `underrun_cnt` out 8: saturating count of reads from empty EP2.
- `overrun_cnt` out 8: saturating count of writes to full EP6.
- `zlp_cnt` out 8: saturating count of zero-length packet ends.

## Operation
- **EP2, host push.** `host_out_ready` = (ep2_count < DEPTH), combinational. Transfer when valid && ready.
- **EP2, FPGA read.**
  - `FDI` = EP2 head when SLOE && FIFOADR==00, else 8'h00. Combinational from FIFO storage.
  - SLRD && FIFOADR==00 pops on the edge.
  - If EP2 is empty: the read is ignored and `underrun_cnt` increments.
- **EP6, FPGA write.** SLWR && FIFOADR==10 stores {last, FDO}.
  - last=1 when PKTEND is asserted the same cycle, or when this byte makes `pkt_bytes` reach PKT_SIZE.
  - If EP6 is full: the byte is dropped and `overrun_cnt` increments.
  - `pkt_bytes` is an up-counter, log2(PKT_SIZE)+1 bits. It clears on any stored byte with last=1, otherwise increments per stored byte.
- **EP6, PKTEND without SLWR** (FIFOADR==10):
  - If the tail entry exists and its last=0: set the tail's last bit and clear `pkt_bytes`.
  - Otherwise (EP6 empty, or tail already last): increment `zlp_cnt`. No entry is written.
- **EP6, host pop.** `host_in_valid` = EP6 not empty. `host_in_data`/`host_in_last` = head. Pop when valid && ready.
- **EP4/EP8 addresses.** Strobes addressed there are ignored: no counter or state change.
- **Simultaneous push and pop** on the same FIFO in one cycle: both occur and the count is unchanged. A pop on a full FIFO frees space for the same-cycle push. A push on an empty FIFO does not enable a same-cycle pop (no fall-through).
- **Counters.** All counters saturate at 8'hFF.

## Timing
- **Flags** are registered from the post-edge counts. An operation at edge n is visible on FLAGA/FLAGC after edge n+1, a one-cycle lag that matches the FX2. The FPGA master must tolerate this; over-reads and over-writes are counted, never corrupt state.
- **Combinational paths.** `host_out_ready`, `host_in_valid`, `host_in_data` and `FDI` are combinational from FIFO state, with zero latency.
- **Reset (asserted).** Takes effect immediately and asynchronously:
  - both FIFOs empty; `pkt_bytes`, all `*_cnt` = 0;
  - FLAGA–FLAGD = 0; `FDI` = 0; `host_in_valid` = 0; `host_out_ready` = 1.
- **Reset (released).** FLAGC rises one edge after release. Reset mid-packet discards all queued data and any partial-packet state.

## Structure
- **Shared package `fx2_pkg`:**
  - FIFOADR constants `EP2`, `EP4`, `EP6`, `EP8`;
  - the 9-bit EP6 entry type {last, data};
  - the saturating-increment function.
- **Sub-module `fx2_emu_fifo`:** synchronous FIFO parameterized on width and depth, instantiated twice (8-bit for EP2, 9-bit for EP6).
  - Ports: push, pop, head, count, full, empty, plus a `set_tail_last` strobe for PKTEND.
  - Pointers are log2(DEPTH)+1 bits and wrap naturally.

## Test plan
- **EP2 stream.** Host pushes 0x10..0x1F (16 bytes, DEPTH=16) → `host_out_ready`=0 after the 16th. With SLOE=1 and FIFOADR=00, 16 SLRD cycles → FDI reads 0x10..0x1F in order. FLAGA falls one cycle after the last pop.
- **Underrun.** SLRD held two cycles beyond empty (flag lag) → `underrun_cnt`=2, FDI=0x00, FIFO still empty.
- **EP6 full.** 17 SLWR writes of 0xA0+i → 16 stored, `overrun_cnt`=1, FLAGC=0 one cycle after the 16th write. Host pops 0xA0..0xAF, all with last=0.
- **Packet ends.** Write 3 bytes, then PKTEND alone → 3rd byte popped with last=1. A second PKTEND alone → `zlp_cnt`=1. SLWR+PKTEND together on 0x55 → 0x55 popped with last=1.
- **Auto packet end.** PKT_SIZE=8: host drains continuously while 10 bytes are written → bytes 8 and (if PKTEND follows) 10 carry last. Check the auto end on byte 8 and that `pkt_bytes` restarts.
- **Reset mid-operation.** Reset asserted with 5 bytes queued in each FIFO → both empty, all counters 0, FLAGC=1 one edge after release.
